// File: rtl/pkg_config.sv
// Shared fetch/branch configuration: datapath width, branch op encodings,
// PC sequencer states and default PC unit constants.
package pkg_config;

   localparam int DATA_WIDTH = 32;

   typedef enum logic [2:0] {
      BR_EQ  = 3'd0,
      BR_NE  = 3'd1,
      BR_LT  = 3'd4,
      BR_GE  = 3'd5,
      BR_LTU = 3'd6,
      BR_GEU = 3'd7
   } br_op_t;

   typedef enum logic [1:0] {
      BOOT  = 2'd0,
      RUN   = 2'd1,
      FLUSH = 2'd2
   } pc_state_t;

   localparam logic [DATA_WIDTH-1:0] RESET_VECTOR_DEF = 32'h0000_0000;
   localparam logic [DATA_WIDTH-1:0] TRAP_VECTOR_DEF  = 32'h0000_0100;
   localparam int                    FLUSH_CYCLES_DEF = 2;
   localparam int                    FLUSH_CNT_W      = $clog2(8);

endpackage

// File: rtl/flush_counter.sv
// Loadable down-counter that saturates at zero; done_o flags a zero count.
module flush_counter
   import pkg_config::*;
#(
   parameter int W = FLUSH_CNT_W
) (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic         load_i,
   input  logic [W-1:0] load_val_i,
   input  logic         dec_i,
   output logic         done_o
);

   logic [W-1:0] count_q;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         count_q <= '0;
      end else if (load_i) begin
         count_q <= load_val_i;
      end else if (dec_i && (count_q != '0)) begin
         count_q <= count_q - 1'b1;
      end
   end

   assign done_o = (count_q == '0);

endmodule

// File: rtl/pc_unit.sv
// Fetch-side program counter with redirect and multi-cycle flush.
// Optional misaligned-target trap is enabled by defining PC_MISALIGN_TRAP_EN.
//
// state | meaning
// BOOT  | first cycle out of reset, PC not yet valid
// RUN   | normal fetch, +4 per cycle unless stalled, accepts redirects
// FLUSH | redirect in progress, flush_o high, further redirects ignored
module pc_unit
   import pkg_config::*;
#(
   parameter logic [DATA_WIDTH-1:0] RESET_VECTOR = RESET_VECTOR_DEF,
`ifdef PC_MISALIGN_TRAP_EN
   parameter logic [DATA_WIDTH-1:0] TRAP_VECTOR  = TRAP_VECTOR_DEF,
`endif
   parameter int                    FLUSH_CYCLES = FLUSH_CYCLES_DEF
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  stall_i,
   input  logic                  take_i,
   input  logic [DATA_WIDTH-1:0] target_i,
   output logic [DATA_WIDTH-1:0] pc_o,
   output logic                  pc_valid_o,
   output logic                  flush_o,
   output logic                  misalign_o,
   output logic [DATA_WIDTH-1:0] bad_addr_o
);

   pc_state_t             state_q, state_nxt;
   logic [DATA_WIDTH-1:0] pc_nxt, pc_inc, redirect_pc;
   logic                  valid_nxt, flush_nxt;
   logic                  cnt_load, cnt_dec, cnt_done;
   logic                  misaligned, trap_nxt;

   assign pc_inc = pc_o + DATA_WIDTH'(4);

   always_comb begin
      misaligned  = 1'b0;
      redirect_pc = target_i & ~DATA_WIDTH'(3);
`ifdef PC_MISALIGN_TRAP_EN
      misaligned = (target_i[1:0] != 2'b00);
      if (misaligned) begin
         redirect_pc = TRAP_VECTOR;
      end
`endif
   end

   always_comb begin
      state_nxt = state_q;
      pc_nxt    = pc_o;
      valid_nxt = pc_valid_o;
      flush_nxt = flush_o;
      trap_nxt  = 1'b0;
      cnt_load  = 1'b0;
      cnt_dec   = 1'b0;
      case (state_q)
         BOOT: begin
            state_nxt = RUN;
            valid_nxt = 1'b1;
         end
         RUN: begin
            if (take_i) begin
               pc_nxt    = redirect_pc;
               cnt_load  = 1'b1;
               flush_nxt = 1'b1;
               trap_nxt  = misaligned;
               state_nxt = FLUSH;
            end else if (!stall_i) begin
               pc_nxt = pc_inc;
            end
         end
         FLUSH: begin
            // take_i here belongs to a killed instruction and must not redirect
            if (!stall_i) begin
               pc_nxt = pc_inc;
            end
            cnt_dec = 1'b1;
            if (cnt_done) begin
               flush_nxt = 1'b0;
               state_nxt = RUN;
            end
         end
         default: begin
            state_nxt = BOOT;
            valid_nxt = 1'b0;
            flush_nxt = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q    <= BOOT;
         pc_o       <= RESET_VECTOR;
         pc_valid_o <= 1'b0;
         flush_o    <= 1'b0;
      end else begin
         state_q    <= state_nxt;
         pc_o       <= pc_nxt;
         pc_valid_o <= valid_nxt;
         flush_o    <= flush_nxt;
      end
   end

`ifdef PC_MISALIGN_TRAP_EN
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         misalign_o <= 1'b0;
         bad_addr_o <= '0;
      end else begin
         misalign_o <= trap_nxt;
         if (trap_nxt) begin
            bad_addr_o <= target_i;
         end
      end
   end
`else
   logic unused_trap;
   assign unused_trap = trap_nxt;
   assign misalign_o  = 1'b0;
   assign bad_addr_o  = '0;
`endif

   flush_counter #(
      .W (FLUSH_CNT_W)
   ) u_flush_counter (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .load_i     (cnt_load),
      .load_val_i (FLUSH_CNT_W'(FLUSH_CYCLES - 1)),
      .dec_i      (cnt_dec),
      .done_o     (cnt_done)
   );

endmodule

// File: tb/tb_pc_unit.sv
// Directed bench for pc_unit with a per-cycle expectation queue.
module tb_pc_unit;
   import pkg_config::*;

   logic                  clk_i = 1'b0;
   logic                  rst_i, stall_i, take_i;
   logic [DATA_WIDTH-1:0] target_i;
   logic [DATA_WIDTH-1:0] pc_o, bad_addr_o;
   logic                  pc_valid_o, flush_o, misalign_o;

`ifdef PC_MISALIGN_TRAP_EN
   localparam logic TRAP_ON = 1'b1;
`else
   localparam logic TRAP_ON = 1'b0;
`endif

   typedef struct {
      logic [31:0] pc;
      logic        valid;
      logic        flush;
      logic        mis;
      logic [31:0] bad;
      string       tag;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;

   pc_unit dut (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .stall_i    (stall_i),
      .take_i     (take_i),
      .target_i   (target_i),
      .pc_o       (pc_o),
      .pc_valid_o (pc_valid_o),
      .flush_o    (flush_o),
      .misalign_o (misalign_o),
      .bad_addr_o (bad_addr_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic cyc(input logic rst, input logic take, input logic stall,
                      input logic [31:0] tgt, input logic [31:0] e_pc,
                      input logic e_val, input logic e_fl, input logic e_mis,
                      input logic [31:0] e_bad, input string tag);
      exp_t e;
      rst_i    = rst;
      take_i   = take;
      stall_i  = stall;
      target_i = tgt;
      sb.push_back('{pc: e_pc, valid: e_val, flush: e_fl, mis: e_mis, bad: e_bad, tag: tag});
      @(posedge clk_i);
      #1;
      e = sb.pop_front();
      check({e.tag, ".pc"},    pc_o,                e.pc);
      check({e.tag, ".valid"}, {31'd0, pc_valid_o}, {31'd0, e.valid});
      check({e.tag, ".flush"}, {31'd0, flush_o},    {31'd0, e.flush});
      check({e.tag, ".mis"},   {31'd0, misalign_o}, {31'd0, e.mis});
      check({e.tag, ".bad"},   bad_addr_o,          e.bad);
      check({e.tag, ".lsb"},   {30'd0, pc_o[1:0]},  32'd0);
   endtask

   initial begin
      logic [31:0] bad;
      bad = 32'h0;
      rst_i = 1'b1; take_i = 1'b0; stall_i = 1'b0; target_i = '0;

      // reset and boot
      cyc(1, 0, 0, 0, 32'h0, 0, 0, 0, bad, "rst0");
      cyc(1, 0, 0, 0, 32'h0, 0, 0, 0, bad, "rst1");
      cyc(0, 0, 0, 0, 32'h0, 1, 0, 0, bad, "boot");
      cyc(0, 0, 0, 0, 32'h4, 1, 0, 0, bad, "run4");
      cyc(0, 0, 0, 0, 32'h8, 1, 0, 0, bad, "run8");
      cyc(0, 0, 0, 0, 32'hC, 1, 0, 0, bad, "runC");
      cyc(0, 0, 0, 0, 32'h10, 1, 0, 0, bad, "run10");

      // redirect with ignored takes during the flush
      cyc(0, 1, 0, 32'h200, 32'h200, 1, 1, 0, bad, "redir");
      cyc(0, 1, 0, 32'h400, 32'h204, 1, 1, 0, bad, "ign1");
      cyc(0, 1, 0, 32'h400, 32'h208, 1, 0, 0, bad, "ign2");
      cyc(0, 0, 0, 0,       32'h20C, 1, 0, 0, bad, "post");

      // take with stall, stall held through and past the flush
      cyc(0, 1, 1, 32'h80, 32'h80, 1, 1, 0, bad, "tkst");
      cyc(0, 0, 1, 0,      32'h80, 1, 1, 0, bad, "st1");
      cyc(0, 0, 1, 0,      32'h80, 1, 0, 0, bad, "st2");
      cyc(0, 0, 1, 0,      32'h80, 1, 0, 0, bad, "st3");
      cyc(0, 0, 0, 0,      32'h84, 1, 0, 0, bad, "unst");

      // wraparound
      cyc(0, 1, 0, 32'hFFFF_FFF8, 32'hFFFF_FFF8, 1, 1, 0, bad, "wrp0");
      cyc(0, 0, 0, 0,             32'hFFFF_FFFC, 1, 1, 0, bad, "wrp1");
      cyc(0, 0, 0, 0,             32'h0000_0000, 1, 0, 0, bad, "wrp2");
      cyc(0, 0, 0, 0,             32'h0000_0004, 1, 0, 0, bad, "wrp3");

      // misaligned target 0x102: both builds land on 0x100
      if (TRAP_ON) bad = 32'h102;
      cyc(0, 1, 0, 32'h102, 32'h100, 1, 1, TRAP_ON, bad, "mis0");
      cyc(0, 0, 0, 0,       32'h104, 1, 1, 0,       bad, "mis1");
      cyc(0, 0, 0, 0,       32'h108, 1, 0, 0,       bad, "mis2");

      // reset during the first flush cycle
      cyc(0, 1, 0, 32'h300, 32'h300, 1, 1, 0, bad, "pre_rst");
      bad = 32'h0;
      cyc(1, 0, 0, 0, 32'h0, 0, 0, 0, bad, "mid_rst");
      cyc(0, 0, 0, 0, 32'h0, 1, 0, 0, bad, "reboot");
      cyc(0, 0, 0, 0, 32'h4, 1, 0, 0, bad, "rerun");

      checks++;
      assert (sb.size() == 0) else begin
         errors++;
         $error("FAIL sb_empty observed %0d expected 0", sb.size());
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/pc_unit.md
# pc_unit

- Fetch-side program counter that consumes the branch unit's taken decision (`take_o`) and the computed target.
- Holds and advances the PC.
- On a redirect, loads the target and raises a multi-cycle flush that kills younger in-flight instructions.
- Sits between the execute-stage branch unit and instruction fetch; optionally traps misaligned targets.

## Interface
- `RESET_VECTOR`, default 32'h0000_0000: PC value after reset.
- `TRAP_VECTOR`, default 32'h0000_0100: PC loaded on a misaligned redirect (only with the macro).
- `FLUSH_CYCLES`, default 2: cycles `flush_o` stays high per redirect; legal range 1..7.
- `clk_i` in 1: clock, rising edge.
- `rst_i` in 1: synchronous, active-high reset.
- `stall_i` in 1: fetch not ready; hold PC.
- `take_i` in 1: redirect request, driven by the branch unit `take_o`.
- `target_i` in DATA_WIDTH: redirect target address.
- `pc_o` out DATA_WIDTH: current fetch PC.
- `pc_valid_o` out 1: `pc_o` is a valid fetch request.
- `flush_o` out 1: kill all instructions younger than the redirecting one.
- `misalign_o` out 1: one-cycle pulse, misaligned target trapped.
- `bad_addr_o` out DATA_WIDTH: offending target, held until the next trap or reset.

## Operation
- All outputs are registered.
- States: BOOT, RUN, FLUSH.
- Reset values: `pc_o`=RESET_VECTOR, `pc_valid_o`=0, `flush_o`=0, `misalign_o`=0, `bad_addr_o`=0, state BOOT.
- BOOT: lasts one cycle, then RUN. `pc_valid_o` goes 1 and `pc_o` stays RESET_VECTOR.
- RUN, `take_i`=1 (has priority over `stall_i`):
  - pc <= target.
  - flush counter <= FLUSH_CYCLES-1.
  - `flush_o` <= 1; state -> FLUSH.
- RUN, `take_i`=0, `stall_i`=1: pc holds.
- RUN, otherwise: pc <= pc + 4.
- FLUSH:
  - `take_i` is ignored; it comes from an instruction being killed.
  - PC advances by +4 unless `stall_i` is high.
  - The counter decrements every cycle, independent of `stall_i`.
  - When the counter = 0 and it decrements: `flush_o` <= 0, state -> RUN.
- Arithmetic: PC increment is modulo 2^DATA_WIDTH, so 32'hFFFF_FFFC + 4 = 32'h0000_0000 with no flag.
- `pc_o[1:0]` is always 2'b00.
- Reset mid-FLUSH or mid-stall: `rst_i` overrides everything; the next edge restores reset values.
- `rst_i` held high keeps BOOT values.

## Timing
- `take_i` sampled at edge N:
  - `pc_o`=target from cycle N+1.
  - `flush_o` high for cycles N+1 .. N+FLUSH_CYCLES.
  - First accepted new `take_i` is at edge N+FLUSH_CYCLES+1.
- Redirect latency is 1 cycle; there is no combinational path from any input to any output.
- Back-to-back `take_i` in FLUSH cycles produces no extra redirect and no flush extension.
- Stall during FLUSH:
  - Flush length is unchanged.
  - PC stays at the target while `stall_i` is high.

## Configuration
- `PC_MISALIGN_TRAP_EN` defined, redirect with `target_i[1:0]`≠0:
  - pc <= TRAP_VECTOR.
  - `bad_addr_o` <= `target_i`.
  - `misalign_o`=1 for the single cycle N+1.
  - Flush proceeds exactly as for a normal redirect.
- `PC_MISALIGN_TRAP_EN` undefined:
  - pc <= {`target_i`[DATA_WIDTH-1:2], 2'b00}.
  - `misalign_o` and `bad_addr_o` are tied to 0.
  - Trap logic is absent.

## Structure
- Goes in `pkg_config`, next to DATA_WIDTH and the branch op encodings:
  - `pc_state_t` enum (BOOT, RUN, FLUSH).
  - Default RESET_VECTOR, TRAP_VECTOR and FLUSH_CYCLES constants.
- One sub-module, `flush_counter`: loadable down-counter with a done flag, width $clog2(8)=3.
- Everything else stays inline.

## Test plan
- Reset, release, 4 cycles with no stall:
  - One BOOT cycle shows 0x0, `pc_valid_o`=0.
  - Then `pc_o` reads 0x0, 0x4, 0x8, 0xC with `pc_valid_o`=1.
- RUN at 0x10, `take_i`=1, `target_i`=0x200, FLUSH_CYCLES=2:
  - Next cycles `pc_o` = 0x200, 0x204.
  - `flush_o` is high exactly 2 cycles.
  - `take_i`=1 to 0x400 during those cycles is ignored.
- Simultaneous `take_i`=1 and `stall_i`=1 with target 0x80:
  - `pc_o`=0x80 next cycle.
  - `stall_i` held 3 cycles keeps 0x80.
  - `flush_o` still drops after 2 cycles.
- PC at 0xFFFF_FFF8, no stall:
  - `pc_o` reads 0xFFFF_FFFC, then 0x0000_0000.
- With `PC_MISALIGN_TRAP_EN`, `take_i`=1, `target_i`=0x102:
  - `pc_o`=0x100 (TRAP_VECTOR), `misalign_o` pulses 1 cycle, `bad_addr_o`=0x102, `flush_o` high 2 cycles.
  - Without the macro, `pc_o`=0x100 and `misalign_o` stays 0.
- `rst_i` asserted on the first FLUSH cycle:
  - Next cycle `pc_o`=0x0, `flush_o`=0, `pc_valid_o`=0 (BOOT).
